// File: rtl/mem_port_sequencer_pkg.sv
// Shared processor defines: load/store funct3 codes, response FSM states and
// the registered memory command bundle.
package mem_port_sequencer_pkg;

    // RISC-V load funct3 encodings. Stores reuse B/H/W.
    localparam logic [2:0] LS_FUNCT3_B  = 3'b000;
    localparam logic [2:0] LS_FUNCT3_H  = 3'b001;
    localparam logic [2:0] LS_FUNCT3_W  = 3'b010;
    localparam logic [2:0] LS_FUNCT3_BU = 3'b100;
    localparam logic [2:0] LS_FUNCT3_HU = 3'b101;

    // Per-path response FSM.
    typedef enum logic {
        MPS_IDLE = 1'b0,
        MPS_BUSY = 1'b1
    } mps_state_t;

    // Registered memory command, excluding the address.
    typedef struct packed {
        logic        is_inst;
        logic        read;
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } mem_cmd_t;

    localparam mem_cmd_t MEM_CMD_NOP = '0;

endpackage

// File: rtl/mem_port_sequencer_ls_align_check.sv
// Alignment check for one memory request. Fetches must be word aligned,
// halfword accesses need addr[0]=0 and word accesses need addr[1:0]=0.
module ls_align_check
    import mem_port_sequencer_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr,
    input  logic       is_inst,
    output logic       misaligned
);

    // Decode the access size and test the low address bits.
    always_comb begin
        misaligned = 1'b0;
        if (is_inst) begin
            misaligned = |addr;
        end else begin
            case (funct3)
                LS_FUNCT3_H, LS_FUNCT3_HU: misaligned = addr[0];
                LS_FUNCT3_W:               misaligned = |addr;
                default:                   misaligned = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Arbitrates instruction fetch and load/store onto the single memory port.
// The command is registered so the memory sees clean one-cycle commands.
// The combinational read result is captured one cycle later, giving a
// 2-cycle request-to-response latency with one access per cycle.
module mem_port_sequencer
    import mem_port_sequencer_pkg::*;
#(
    parameter int STARVE_LIMIT = 2,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    // fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_stall,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    output logic              if_misaligned,
    // load/store side
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ack,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              ls_misaligned,
    // memory port
    output logic              mem_is_inst,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W:0]   mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

    logic            grant_d, grant_i;
    logic [1:0]      starve_cnt;
    logic            if_mis, ls_mis;
    mem_cmd_t        cmd_d, cmd_q;
    logic [ADDR_W:0] addr_d, addr_q;
    // Tags travelling with the command into the capture cycle.
    logic            if_mis_q, ls_mis_q, ls_store_q;
    mps_state_t      if_state, if_next, ls_state, ls_next;
    logic            if_capture, ls_capture;

    ls_align_check u_if_align (
        .funct3     (LS_FUNCT3_W),
        .addr       (if_addr[1:0]),
        .is_inst    (1'b1),
        .misaligned (if_mis)
    );

    ls_align_check u_ls_align (
        .funct3     (ls_funct3),
        .addr       (ls_addr[1:0]),
        .is_inst    (1'b0),
        .misaligned (ls_mis)
    );

    // Data wins by default; fetch takes the port once data has starved it.
    always_comb begin
        grant_d = ls_req & ~(if_req & (starve_cnt == LIMIT));
        grant_i = if_req & ~grant_d;
    end

    assign if_ack   = grant_i;
    assign ls_ack   = grant_d;
    assign if_stall = if_req & ~grant_i;

    // Count data grants taken while a fetch is waiting.
    always_ff @(posedge clk) begin
        if (rst || !if_req || grant_i) starve_cnt <= 2'd0;
        else if (grant_d)              starve_cnt <= starve_cnt + 2'd1;
    end

    // Build the next memory command; misaligned requests become a NOP.
    always_comb begin
        cmd_d  = MEM_CMD_NOP;
        addr_d = '0;
        if (grant_d) begin
            cmd_d.read   = ~ls_we & ~ls_mis;
            cmd_d.write  = ls_we & ~ls_mis;
            cmd_d.funct3 = ls_funct3;
            cmd_d.wdata  = ls_we ? ls_wdata : 32'd0;
            addr_d       = {1'b0, ls_addr};
        end else if (grant_i) begin
            cmd_d.is_inst = ~if_mis;
            cmd_d.funct3  = LS_FUNCT3_W;
            addr_d        = {1'b0, if_addr};
        end
    end

    // Command registers; with no grant they fall back to NOP so a write never repeats.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= MEM_CMD_NOP;
            addr_q     <= '0;
            if_mis_q   <= 1'b0;
            ls_mis_q   <= 1'b0;
            ls_store_q <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            if_mis_q   <= grant_i & if_mis;
            ls_mis_q   <= grant_d & ls_mis;
            ls_store_q <= grant_d & ls_we;
        end
    end

    assign mem_is_inst = cmd_q.is_inst;
    assign mem_read    = cmd_q.read;
    assign mem_write   = cmd_q.write;
    assign mem_funct3  = cmd_q.funct3;
    assign mem_wdata   = cmd_q.wdata;
    assign mem_addr    = addr_q;

    // Response FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_state <= MPS_IDLE;
            ls_state <= MPS_IDLE;
        end else begin
            if_state <= if_next;
            ls_state <= ls_next;
        end
    end

    // BUSY means the memory is serving that path this cycle.
    always_comb begin
        if_next    = grant_i ? MPS_BUSY : MPS_IDLE;
        ls_next    = grant_d ? MPS_BUSY : MPS_IDLE;
        if_capture = (if_state == MPS_BUSY);
        ls_capture = (ls_state == MPS_BUSY);
    end

    // Capture the read result and raise the one-cycle response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid      <= 1'b0;
            if_inst       <= 32'd0;
            if_misaligned <= 1'b0;
            ls_done       <= 1'b0;
            ls_rdata      <= 32'd0;
            ls_misaligned <= 1'b0;
        end else begin
            if_valid      <= if_capture;
            if_misaligned <= if_capture & if_mis_q;
            if (if_capture) if_inst <= if_mis_q ? 32'd0 : mem_rdata;
            ls_done       <= ls_capture;
            ls_misaligned <= ls_capture & ls_mis_q;
            if (ls_capture) ls_rdata <= (ls_mis_q | ls_store_q) ? 32'd0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer with a byte-addressed memory model.
module tb_mem_port_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ack, if_stall, if_valid, if_misaligned;
    logic [31:0] if_inst;
    logic        ls_req, ls_we;
    logic [2:0]  ls_funct3;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack, ls_done, ls_misaligned;
    logic [31:0] ls_rdata;
    logic        mem_is_inst, mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        poke_en;
    logic [8:0]  poke_addr;
    logic [31:0] poke_data;
    logic [7:0]  mem [0:511];
    logic [7:0]  b0, b1, b2, b3;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_sequencer #(.STARVE_LIMIT(2), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_stall(if_stall),
        .if_valid(if_valid), .if_inst(if_inst), .if_misaligned(if_misaligned),
        .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ls_misaligned(ls_misaligned),
        .mem_is_inst(mem_is_inst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory writes: bench preload pokes, else level-sensitive store at the edge.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr]        <= poke_data[7:0];
            mem[poke_addr + 9'd1] <= poke_data[15:8];
            mem[poke_addr + 9'd2] <= poke_data[23:16];
            mem[poke_addr + 9'd3] <= poke_data[31:24];
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[mem_addr + 9'd1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_addr + 9'd2] <= mem_wdata[23:16];
                mem[mem_addr + 9'd3] <= mem_wdata[31:24];
            end
        end
    end

    // Combinational read with load extension done by the memory.
    always_comb begin
        mem_rdata = 32'd0;
        b0 = mem[mem_addr];
        b1 = mem[mem_addr + 9'd1];
        b2 = mem[mem_addr + 9'd2];
        b3 = mem[mem_addr + 9'd3];
        if (mem_is_inst) mem_rdata = {b3, b2, b1, b0};
        else if (mem_read) begin
            case (mem_funct3)
                3'b000:  mem_rdata = {{24{b0[7]}}, b0};
                3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
                3'b010:  mem_rdata = {b3, b2, b1, b0};
                3'b100:  mem_rdata = {24'd0, b0};
                3'b101:  mem_rdata = {16'd0, b1, b0};
                default: mem_rdata = 32'd0;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke_word(input logic [8:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick;
        poke_en = 1'b0;
    endtask

    task automatic fetch_op(input string tag, input logic [7:0] a,
                            input logic [31:0] exp_inst, input logic exp_mis);
        if_addr = a; if_req = 1'b1;
        @(negedge clk);
        chk({tag, ".ack"}, 32'(if_ack), 32'd1);
        chk({tag, ".stall"}, 32'(if_stall), 32'd0);
        tick;
        if_req = 1'b0;
        @(negedge clk);
        chk({tag, ".is_inst"}, 32'(mem_is_inst), 32'(!exp_mis));
        chk({tag, ".rd_wr"}, 32'({mem_read, mem_write}), 32'd0);
        chk({tag, ".funct3"}, 32'(mem_funct3), 32'd2);
        chk({tag, ".addr"}, 32'(mem_addr), 32'(a));
        tick;
        @(negedge clk);
        chk({tag, ".valid"}, 32'(if_valid), 32'd1);
        chk({tag, ".inst"}, if_inst, exp_inst);
        chk({tag, ".mis"}, 32'(if_misaligned), 32'(exp_mis));
        tick;
        @(negedge clk);
        chk({tag, ".valid_off"}, 32'(if_valid), 32'd0);
    endtask

    task automatic ls_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [7:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_mis);
        ls_we = we; ls_funct3 = f3; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
        @(negedge clk);
        chk({tag, ".ack"}, 32'(ls_ack), 32'd1);
        chk({tag, ".if_ack"}, 32'(if_ack), 32'd0);
        chk({tag, ".done_prev"}, 32'(ls_done), 32'd0);
        tick;
        ls_req = 1'b0;
        @(negedge clk);
        chk({tag, ".mem_read"}, 32'(mem_read), 32'(!we && !exp_mis));
        chk({tag, ".mem_write"}, 32'(mem_write), 32'(we && !exp_mis));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(a));
        tick;
        @(negedge clk);
        chk({tag, ".done"}, 32'(ls_done), 32'd1);
        chk({tag, ".rdata"}, ls_rdata, exp_rd);
        chk({tag, ".mis"}, 32'(ls_misaligned), 32'(exp_mis));
        chk({tag, ".write_once"}, 32'(mem_write), 32'd0);
        chk({tag, ".read_off"}, 32'(mem_read), 32'd0);
        tick;
    endtask

    initial begin
        rst = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = '0; ls_addr = '0; ls_wdata = '0;
        tick;
        poke_word(9'd0, 32'h01100093);
        poke_word(9'd4, 32'h00000013);
        @(negedge clk);
        chk("reset.mem_ctl", 32'({mem_is_inst, mem_read, mem_write}), 32'd0);
        chk("reset.mem_addr", 32'(mem_addr), 32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'd0);
        chk("reset.pulses", 32'({if_valid, ls_done, if_misaligned, ls_misaligned}), 32'd0);
        chk("reset.if_inst", if_inst, 32'd0);
        chk("reset.ls_rdata", ls_rdata, 32'd0);
        tick;
        rst = 1'b0;

        fetch_op("fetch0", 8'd0, 32'h01100093, 1'b0);
        fetch_op("fetch_mis", 8'd2, 32'd0, 1'b1);

        poke_word(9'd0, 32'h03190103);
        ls_op("lw0", 1'b0, 3'b010, 8'd0, 32'd0, 32'h03190103, 1'b0);
        ls_op("lb2", 1'b0, 3'b000, 8'd2, 32'd0, 32'h00000019, 1'b0);
        ls_op("sw8", 1'b1, 3'b010, 8'd8, 32'hDEADBEEF, 32'd0, 1'b0);
        ls_op("lw8", 1'b0, 3'b010, 8'd8, 32'd0, 32'hDEADBEEF, 1'b0);
        ls_op("lb11", 1'b0, 3'b000, 8'd11, 32'd0, 32'hFFFFFFDE, 1'b0);
        ls_op("lh_mis", 1'b0, 3'b001, 8'd1, 32'd0, 32'd0, 1'b1);
        ls_op("sw_mis", 1'b1, 3'b010, 8'd6, 32'h11111111, 32'd0, 1'b1);
        ls_op("lw8_keep", 1'b0, 3'b010, 8'd8, 32'd0, 32'hDEADBEEF, 1'b0);
        ls_op("lbu11", 1'b0, 3'b100, 8'd11, 32'd0, 32'h000000DE, 1'b0);

        // Both requesters held: D,D,I,D,D,I
        ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 8'd0; ls_req = 1'b1;
        if_addr = 8'd4; if_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("starve%0d.ls_ack", k), 32'(ls_ack), 32'((k % 3) != 2));
            chk($sformatf("starve%0d.if_ack", k), 32'(if_ack), 32'((k % 3) == 2));
            chk($sformatf("starve%0d.stall", k), 32'(if_stall), 32'((k % 3) != 2));
            tick;
        end
        ls_req = 1'b0; if_req = 1'b0;
        tick; tick; tick;

        // Store accepted, then reset lands in the cycle the write is driven.
        ls_op("lbu11_b", 1'b0, 3'b100, 8'd11, 32'd0, 32'h000000DE, 1'b0);
        ls_we = 1'b1; ls_funct3 = 3'b010; ls_addr = 8'd16; ls_wdata = 32'h12345678;
        ls_req = 1'b1;
        @(negedge clk);
        chk("rst_mid.ack", 32'(ls_ack), 32'd1);
        tick;
        ls_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.write_n1", 32'(mem_write), 32'd1);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.mem_ctl", 32'({mem_is_inst, mem_read, mem_write}), 32'd0);
        chk("rst_mid.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mid.mem_wdata", mem_wdata, 32'd0);
        chk("rst_mid.pulses", 32'({if_valid, ls_done, if_misaligned, ls_misaligned}), 32'd0);
        chk("rst_mid.ls_rdata", ls_rdata, 32'd0);
        chk("rst_mid.if_inst", if_inst, 32'd0);
        tick;
        @(negedge clk);
        chk("rst_mid.no_done", 32'(ls_done), 32'd0);
        chk("rst_mid.no_write", 32'(mem_write), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_sequencer.md
# mem_port_sequencer

Requester-side controller for the processor's single unified memory. It accepts instruction-fetch and load/store requests from the pipeline and arbitrates them onto the one memory port. It drives that port from registers so the level-sensitive write path sees clean, single-cycle commands. It captures the combinational read result and returns it to the pipeline, raising a stall whenever the fetch stage loses arbitration.

## Interface
Parameters:
- STARVE_LIMIT, 2: consecutive data grants allowed while a fetch waits; the next grant goes to fetch.
- ADDR_W, 8: pipeline byte-address width. The memory port address is {1'b0, addr}.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  combinational; fetch accepted this cycle.
- if_stall  out  1  combinational; if_req & ~if_ack.
- if_valid  out  1  one-cycle pulse; if_inst is valid.
- if_inst  out  32  fetched instruction (registered).
- if_misaligned  out  1  qualifies if_valid; if_addr[1:0]≠0.
- ls_req  in  1  load/store request; held until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_funct3  in  3  RISC-V load/store funct3.
- ls_addr  in  ADDR_W  data byte address.
- ls_wdata  in  32  store data.
- ls_ack  out  1  combinational; load/store accepted.
- ls_done  out  1  one-cycle pulse; access completed.
- ls_rdata  out  32  load result, already extended by memory (registered).
- ls_misaligned  out  1  qualifies ls_done.
- mem_is_inst, mem_read, mem_write  out  1  registered memory command.
- mem_funct3  out  3  registered.
- mem_addr  out  9  registered.
- mem_wdata  out  32  registered.
- mem_rdata  in  32  memory read result (combinational from command).

## Operation
- Arbitration (per cycle, combinational):
  - Only ls_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
- starve_cnt (2 bits):
  - Increments on a data grant while if_req is high.
  - Clears on a fetch grant, or on any cycle with if_req low.
- Misalignment:
  - Halfword (H/HU, SH) with addr[0]=1 is misaligned.
  - Word (W, SW) with addr[1:0]≠0 is misaligned.
  - Fetch with addr[1:0]≠0 is misaligned.
  - A misaligned request is still acked, and loads a NOP command: mem_read = mem_write = 0.
  - Its response pulse carries the misaligned flag; ls_rdata/if_inst = 0.
- FSM per response path, with states IDLE and BUSY:
  - IDLE→BUSY on a grant.
  - BUSY→BUSY on a back-to-back grant.
  - BUSY→IDLE when no grant.
  - In BUSY, mem_rdata is captured into the response register and the matching valid/done pulse is generated.
- Stores: mem_write is high for exactly one cycle per accepted store. ls_done pulses with ls_rdata = 0.
- Fetch command: mem_is_inst=1, mem_read=0, mem_write=0, mem_funct3=3'b010.

## Timing
- Cycle N: req & ack.
- End of N: command registers load.
- Cycle N+1: memory is driven.
- End of N+1: mem_rdata is captured.
- Cycle N+2: if_valid/ls_done high for one cycle.
- Latency is 2 cycles. Throughput is 1 access per cycle.
- With no grant, command registers return to NOP (all mem_* controls 0) on the next edge. A write is never held for two cycles.
- Reset values:
  - All mem_* outputs 0.
  - if_valid, ls_done, if_misaligned, ls_misaligned = 0.
  - if_inst, ls_rdata = 0.
  - starve_cnt = 0; FSMs IDLE.
- Reset mid-operation: in-flight commands are dropped. No response pulse follows reset, and any pending write is cancelled at the reset edge.
- if_ack and ls_ack are never both high in one cycle.

## Structure
- Shared processor defines (existing): LS_FUNCT3_B/H/W/BU/HU, plus new MPS_IDLE/MPS_BUSY state encodings.
- One natural sub-module: ls_align_check. It is combinational, with inputs funct3, addr[1:0] and is_inst, and output misaligned.
- Arbiter, command registers and response registers live in the top module.

## Test plan
- Reset, then if_req at addr 0 → if_ack same cycle; if_valid 2 cycles later with if_inst = 0x01100093, misaligned = 0.
- LW at 0 with data bytes 3,1,25,3 → ls_done at N+2, ls_rdata = 0x03190103. LB at 2 → 0x00000019.
- SW 0xDEADBEEF at 8, then LW at 8 → 0xDEADBEEF. LB at 11 → 0xFFFFFFDE. LBU at 11 → 0x000000DE. Check mem_write is high exactly one cycle.
- if_req and ls_req held continuously (STARVE_LIMIT=2) → grant pattern D,D,I,D,D,I. if_stall is high on D cycles.
- LH at addr 1 → ls_done with ls_misaligned=1, ls_rdata=0, and mem_read never asserted.
- Store accepted in cycle N, rst high in N+1 → no mem_write after the reset edge, no ls_done; all outputs 0 the following cycle.
